// File: rtl/uart_rx_frame_ctrl_if.sv
// uart_rx_frame_ctrl_if: UART byte input (rx_data/rx_available/rx_clear), payload write port (wr_*), host frame status (frame_*/err_code/busy)
interface uart_rx_frame_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_available;
  logic       rx_clear;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       frame_done;
  logic [7:0] frame_len;
  logic       frame_ack;
  logic       frame_err;
  logic [2:0] err_code;
  logic       busy;
  modport slave (
    input  rx_data, rx_available, frame_ack,
    output rx_clear, wr_en, wr_addr, wr_data, frame_done, frame_len, frame_err, err_code, busy
  );
  modport master (
    output rx_data, rx_available, frame_ack,
    input  rx_clear, wr_en, wr_addr, wr_data, frame_done, frame_len, frame_err, err_code, busy
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: parses A5/LEN/payload/SUM frames from a UART byte stream; ports clk, rst_n (async low), bus (slave: byte in, payload writes, frame status)
module uart_rx_frame_ctrl #(
  parameter int CLK_FREQ       = 27_000_000,
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = CLK_FREQ / 100
) (
  input logic clk,
  input logic rst_n,
  uart_rx_frame_ctrl_if.slave bus
);
  typedef enum logic [2:0] {S_SYNC, S_LEN, S_PAYLOAD, S_SUM, S_HOLD} state_t;
  state_t r_state;
  logic r_rx_clear, r_wr_en, r_frame_done, r_frame_err;
  logic [7:0] r_wr_addr, r_wr_data, r_frame_len, r_len, r_idx, r_sum;
  logic [2:0] r_err_code;
  logic [23:0] r_idle;
  logic w_acc, w_timed, w_to;
  logic [7:0] w_byte;
  assign w_byte = bus.rx_data;
  assign w_acc = bus.rx_available && !r_rx_clear;
  assign w_timed = r_state inside {S_LEN, S_PAYLOAD, S_SUM};
  assign w_to = w_timed && !w_acc && r_idle == 24'(TIMEOUT_CYCLES - 1);
  assign bus.rx_clear = r_rx_clear;
  assign bus.wr_en = r_wr_en;
  assign bus.wr_addr = r_wr_addr;
  assign bus.wr_data = r_wr_data;
  assign bus.frame_done = r_frame_done;
  assign bus.frame_len = r_frame_len;
  assign bus.frame_err = r_frame_err;
  assign bus.err_code = r_err_code;
  assign bus.busy = r_state != S_SYNC;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SYNC;
      r_rx_clear <= 1'b0;
      r_wr_en <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr <= 8'd0;
      r_wr_data <= 8'd0;
      r_frame_len <= 8'd0;
      r_len <= 8'd0;
      r_idx <= 8'd0;
      r_sum <= 8'd0;
      r_err_code <= 3'd0;
      r_idle <= 24'd0;
    end else begin
      r_rx_clear <= w_acc;
      r_wr_en <= 1'b0;
      r_frame_done <= 1'b0;
      r_frame_err <= 1'b0;
      r_idle <= (w_timed && !w_acc && !w_to) ? r_idle + 24'd1 : 24'd0;
      if (w_to) begin
        r_frame_err <= 1'b1;
        r_err_code <= 3'd3;
        r_state <= S_SYNC;
      end else begin
        case (r_state)
          S_SYNC: if (w_acc && w_byte == 8'hA5) r_state <= S_LEN;
          S_LEN: if (w_acc) begin
            if (w_byte == 8'd0 || w_byte > 8'(MAX_LEN)) begin
              r_frame_err <= 1'b1;
              r_err_code <= 3'd1;
              r_state <= S_SYNC;
            end else begin
              r_len <= w_byte;
              r_sum <= w_byte;
              r_idx <= 8'd0;
              r_state <= S_PAYLOAD;
            end
          end
          S_PAYLOAD: if (w_acc) begin
            r_wr_en <= 1'b1;
            r_wr_addr <= r_idx;
            r_wr_data <= w_byte;
            r_sum <= r_sum + w_byte;
            r_idx <= r_idx + 8'd1;
            if (r_idx == r_len - 8'd1) r_state <= S_SUM;
          end
          S_SUM: if (w_acc) begin
            if (w_byte == r_sum) begin
              r_frame_done <= 1'b1;
              r_frame_len <= r_len;
              r_state <= S_HOLD;
            end else begin
              r_frame_err <= 1'b1;
              r_err_code <= 3'd2;
              r_state <= S_SYNC;
            end
          end
          S_HOLD: begin
            // a byte arriving with the ack is parsed as if already back in S_SYNC
            if (bus.frame_ack) r_state <= (w_acc && w_byte == 8'hA5) ? S_LEN : S_SYNC;
            else if (w_acc) begin
              r_frame_err <= 1'b1;
              r_err_code <= 3'd4;
            end
          end
          default: r_state <= S_SYNC;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// tb_uart_rx_frame_ctrl: randomized and directed frame checks against a frame-level reference model
module tb_uart_rx_frame_ctrl;
  localparam int TO = 200;
  localparam int ML = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  uart_rx_frame_ctrl_if bus();
  uart_rx_frame_ctrl #(.MAX_LEN(ML), .TIMEOUT_CYCLES(TO)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  logic [15:0] wr_q[$];
  logic [7:0] done_q[$];
  logic [2:0] err_q[$];
  logic [15:0] exp_wr[$];
  logic [7:0] exp_done[$];
  logic [2:0] exp_err[$];
  int clr_cnt = 0;
  bit clr_dbl = 0;
  logic clr_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.wr_en) wr_q.push_back({bus.wr_addr, bus.wr_data});
    if (bus.frame_done) done_q.push_back(bus.frame_len);
    if (bus.frame_err) err_q.push_back(bus.err_code);
    if (bus.rx_clear) clr_cnt++;
    if (bus.rx_clear && clr_prev) clr_dbl = 1;
    clr_prev = bus.rx_clear;
  end
  task automatic clear_mon();
    wr_q.delete(); done_q.delete(); err_q.delete();
    exp_wr.delete(); exp_done.delete(); exp_err.delete();
    clr_cnt = 0; clr_dbl = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  // behaves like a UART receiver: flag stays up until the controller clears it
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bus.rx_data = b;
    bus.rx_available = 1'b1;
    do begin @(negedge clk); n++; end while (!bus.rx_clear && n < 8);
    bus.rx_available = 1'b0;
    checks++;
    if (!bus.rx_clear) begin errors++; $display("FAIL accept_%h: rx_clear=%b required 1", b, bus.rx_clear); end
  endtask
  task automatic ack();
    bus.frame_ack = 1'b1;
    @(negedge clk);
    bus.frame_ack = 1'b0;
  endtask
  task automatic test_reset();
    bus.rx_data = 8'h00; bus.rx_available = 1'b0; bus.frame_ack = 1'b0;
    idle(3);
    checks++;
    if ({bus.rx_clear, bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_len, bus.frame_err, bus.err_code, bus.busy} !== 31'd0) begin
      errors++; $display("FAIL reset_outputs: wr_addr=%h frame_len=%h err_code=%0d busy=%b required all 0", bus.wr_addr, bus.frame_len, bus.err_code, bus.busy);
    end
    rst_n = 1'b1;
    idle(2);
  endtask
  task automatic test_good_frame();
    logic [7:0] f[6] = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    clear_mon();
    foreach (f[i]) send_byte(f[i]);
    idle(3);
    checks++;
    if (wr_q.size() != 3 || wr_q[0] !== 16'h0011 || wr_q[1] !== 16'h0122 || wr_q[2] !== 16'h0233) begin
      errors++; $display("FAIL good_writes: got %0d writes %p required (0,11)(1,22)(2,33)", wr_q.size(), wr_q);
    end
    checks++;
    if (done_q.size() != 1 || done_q[0] !== 8'd3 || err_q.size() != 0) begin
      errors++; $display("FAIL good_done: done=%p err=%p required one done len 3 no err", done_q, err_q);
    end
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL good_busy_hold: busy=%b required 1", bus.busy); end
    ack();
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL good_busy_ack: busy=%b required 0", bus.busy); end
  endtask
  task automatic test_bad_sum();
    logic [7:0] f[5] = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    clear_mon();
    foreach (f[i]) send_byte(f[i]);
    idle(2);
    checks++;
    if (err_q.size() != 1 || err_q[0] !== 3'd2 || done_q.size() != 0) begin
      errors++; $display("FAIL bad_sum: err=%p done=%p required err 2 and no done", err_q, done_q);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.err_code !== 3'd2) begin errors++; $display("FAIL bad_sum_state: busy=%b err_code=%0d required 0/2", bus.busy, bus.err_code); end
  endtask
  task automatic test_bad_len();
    logic [7:0] lens[2] = '{8'h00, 8'(ML + 1)};
    foreach (lens[k]) begin
      clear_mon();
      send_byte(8'hA5); send_byte(lens[k]); send_byte(8'h12); send_byte(8'h34);
      idle(2);
      checks++;
      if (err_q.size() != 1 || err_q[0] !== 3'd1 || wr_q.size() != 0 || bus.busy !== 1'b0) begin
        errors++; $display("FAIL bad_len_%h: err=%p writes=%0d busy=%b required err 1, no writes, idle", lens[k], err_q, wr_q.size(), bus.busy);
      end
    end
  endtask
  task automatic test_timeout();
    int n = 0;
    clear_mon();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    while (!bus.frame_err && n < TO + 20) begin @(negedge clk); n++; end
    checks++;
    if (n != TO || bus.err_code !== 3'd3) begin errors++; $display("FAIL timeout_latency: cycles=%0d err_code=%0d required %0d/3", n, bus.err_code, TO); end
    checks++;
    if (bus.busy !== 1'b0 || wr_q.size() != 1 || wr_q[0] !== 16'h0001) begin
      errors++; $display("FAIL timeout_state: busy=%b writes=%p required 0 and one write (0,01)", bus.busy, wr_q);
    end
    idle(2);
    checks++;
    if (err_q.size() != 1 || done_q.size() != 0) begin errors++; $display("FAIL timeout_pulse: err=%p done=%p required single err", err_q, done_q); end
  endtask
  task automatic test_held_available();
    idle(2);
    clear_mon();
    bus.rx_data = 8'h00;
    bus.rx_available = 1'b1;
    idle(10);
    bus.rx_available = 1'b0;
    idle(2);
    checks++;
    if (clr_cnt != 5 || clr_dbl) begin errors++; $display("FAIL held_avail: rx_clear pulses=%0d back_to_back=%0b required 5/0", clr_cnt, clr_dbl); end
  endtask
  task automatic test_hold_drop();
    clear_mon();
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h5A); send_byte(8'h5B);
    idle(2);
    send_byte(8'h33);
    idle(2);
    checks++;
    if (done_q.size() != 1 || err_q.size() != 1 || err_q[0] !== 3'd4) begin errors++; $display("FAIL hold_drop: done=%p err=%p required one done and err 4", done_q, err_q); end
    checks++;
    if (bus.frame_len !== 8'd1 || bus.busy !== 1'b1 || wr_q.size() != 1) begin
      errors++; $display("FAIL hold_keep: frame_len=%0d busy=%b writes=%0d required 1/1/1", bus.frame_len, bus.busy, wr_q.size());
    end
  endtask
  task automatic test_ack_with_sync();
    clear_mon();
    bus.frame_ack = 1'b1;
    send_byte(8'hA5);
    bus.frame_ack = 1'b0;
    send_byte(8'h02); send_byte(8'h10); send_byte(8'h20); send_byte(8'h32);
    idle(2);
    checks++;
    if (done_q.size() != 1 || done_q[0] !== 8'd2 || err_q.size() != 0 || wr_q.size() != 2) begin
      errors++; $display("FAIL ack_sync: done=%p err=%p writes=%0d required done 2, no err, 2 writes", done_q, err_q, wr_q.size());
    end
    ack();
  endtask
  task automatic test_reset_midframe();
    logic [7:0] f[4] = '{8'hA5, 8'h02, 8'hAA, 8'hBB};
    send_byte(8'hA5); send_byte(8'h05); send_byte(8'h01);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.rx_clear, bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_done, bus.frame_len, bus.frame_err, bus.err_code, bus.busy} !== 31'd0) begin
      errors++; $display("FAIL midframe_reset: wr_data=%h frame_len=%h err_code=%0d busy=%b required all 0", bus.wr_data, bus.frame_len, bus.err_code, bus.busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_mon();
    idle(1);
    foreach (f[i]) send_byte(f[i]);
    send_byte(8'h67);
    idle(2);
    checks++;
    if (wr_q.size() != 2 || wr_q[0] !== 16'h00AA || wr_q[1] !== 16'h01BB || done_q.size() != 1 || done_q[0] !== 8'd2 || err_q.size() != 0) begin
      errors++; $display("FAIL post_reset_frame: writes=%p done=%p err=%p required (0,AA)(1,BB) done 2", wr_q, done_q, err_q);
    end
    ack();
  endtask
  task automatic test_random_frames();
    clear_mon();
    for (int f = 0; f < 12; f++) begin
      logic [7:0] len, sum, b;
      bit bad;
      for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
        b = 8'($urandom_range(0, 255));
        send_byte(b == 8'hA5 ? 8'h00 : b);
      end
      len = (f == 0) ? 8'(ML) : 8'($urandom_range(1, 8));
      sum = len;
      send_byte(8'hA5);
      send_byte(len);
      for (int i = 0; i < int'(len); i++) begin
        b = 8'($urandom);
        exp_wr.push_back({8'(i), b});
        sum = sum + b;
        send_byte(b);
      end
      bad = $urandom_range(0, 3) == 0;
      send_byte(bad ? sum ^ 8'($urandom_range(1, 255)) : sum);
      idle(2);
      if (bad) exp_err.push_back(3'd2);
      else begin exp_done.push_back(len); ack(); end
    end
    idle(2);
    checks++;
    if (wr_q.size() != exp_wr.size()) begin errors++; $display("FAIL rand_wr_count: got %0d required %0d", wr_q.size(), exp_wr.size()); end
    for (int i = 0; i < wr_q.size() && i < exp_wr.size(); i++) begin
      checks++;
      if (wr_q[i] !== exp_wr[i]) begin errors++; $display("FAIL rand_wr_%0d: addr/data=%h required %h", i, wr_q[i], exp_wr[i]); end
    end
    checks++;
    if (done_q != exp_done) begin errors++; $display("FAIL rand_done: got %p required %p", done_q, exp_done); end
    checks++;
    if (err_q != exp_err) begin errors++; $display("FAIL rand_err: got %p required %p", err_q, exp_err); end
  endtask
  initial begin
    test_reset();
    test_good_frame();
    test_bad_sum();
    test_bad_len();
    test_timeout();
    test_held_available();
    test_hold_drop();
    test_ack_with_sync();
    test_reset_midframe();
    test_random_frames();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
